psg_mixer: RTL and testbench

PSG_MIXER -- requirements
Module: psg_mixer

---
 rtl/psg_pkg.sv | 5 +
 rtl/psg_sample_tick.sv | 17 +
 rtl/psg_mixer.sv | 86 ++++++++
 tb/tb_psg_mixer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// psg_pkg: mixer FSM states and accumulator width shared by the PSG mixer.
package psg_pkg;
    typedef enum logic [2:0] {IDLE, STEP, CAPTURE, SUM, SAT, OUT} mixer_state_t;
    localparam int MIX_ACC_W = 18;
endpackage

// File: rtl/psg_sample_tick.sv
// psg_sample_tick: free-running sample-period divider, one-cycle tick at count SAMPLE_DIV-1.
module psg_sample_tick #(
    parameter int SAMPLE_DIV = 2268
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = enable && cnt == CW'(SAMPLE_DIV - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= (!enable || tick) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/psg_mixer.sv
// psg_mixer: per-tick step handshake, channel capture and serial sum into one signed sample.
// Define PSG_MIXER_SAT_EN for a saturated sum; otherwise the output is the sum >>> 2.
module psg_mixer
    import psg_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 2268
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH*16-1:0]     ch_sample,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic                     step,
    output logic signed [15:0]       mix_out,
    output logic                     mix_valid,
    input  logic                     mix_ready,
    output logic                     overrun,
    input  logic                     overrun_clr
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    mixer_state_t                 state;
    logic                         tick;
    logic [IW-1:0]                idx;
    logic signed [MIX_ACC_W-1:0]  acc;
    logic signed [15:0]           cap [NUM_CH];
    logic signed [15:0]           mix_next;

    psg_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .tick(tick)
    );

`ifdef PSG_MIXER_SAT_EN
    assign mix_next = acc > MIX_ACC_W'(32767)  ? 16'sh7fff :
                      acc < MIX_ACC_W'(-32768) ? 16'sh8000 : acc[15:0];
`else
    assign mix_next = acc[MIX_ACC_W-1:MIX_ACC_W-16];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step      <= 1'b0;
            mix_valid <= 1'b0;
            mix_out   <= '0;
            overrun   <= 1'b0;
            idx       <= '0;
            acc       <= '0;
            for (int i = 0; i < NUM_CH; i++) cap[i] <= '0;
        end else begin
            overrun <= (tick && state != IDLE) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
            case (state)
                IDLE: if (tick) begin
                    state <= STEP;
                    step  <= 1'b1;
                end
                STEP: state <= CAPTURE;
                CAPTURE: begin
                    for (int i = 0; i < NUM_CH; i++) cap[i] <= ch_valid[i] ? ch_sample[16*i +: 16] : '0;
                    acc   <= '0;
                    idx   <= '0;
                    step  <= 1'b0;
                    state <= SUM;
                end
                SUM: begin
                    acc <= acc + MIX_ACC_W'(cap[idx]);
                    idx <= idx + IW'(1);
                    if (idx == IW'(NUM_CH - 1)) state <= SAT;
                end
                SAT: begin
                    mix_out   <= mix_next;
                    mix_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (mix_ready) begin
                    mix_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psg_mixer.sv
// tb_psg_mixer: directed and random transactions checked against a sum/clamp/shift reference model.
module tb_psg_mixer;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b1;
    logic [63:0]        ch_sample = '0;
    logic [3:0]         ch_valid = '0;
    logic               step;
    logic signed [15:0] mix_out;
    logic               mix_valid;
    logic               mix_ready = 1'b1;
    logic               overrun;
    logic               overrun_clr = 1'b0;
    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;

    psg_mixer #(.NUM_CH(4), .SAMPLE_DIV(16)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ch_sample(ch_sample),
        .ch_valid(ch_valid),
        .step(step),
        .mix_out(mix_out),
        .mix_valid(mix_valid),
        .mix_ready(mix_ready),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model(input logic [63:0] s, input logic [3:0] v);
        int sum = 0;
        for (int i = 0; i < 4; i++) if (v[i]) sum += int'($signed(s[16*i +: 16]));
`ifdef PSG_MIXER_SAT_EN
        return sum > 32767 ? 32767 : sum < -32768 ? -32768 : sum;
`else
        return sum >>> 2;
`endif
    endfunction

    task automatic check(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rise(output int rise);
        int n = 0;
        while (step !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("step_rise", step, 1);
        rise = cyc;
    endtask

    task automatic txn(input logic [63:0] s, input logic [3:0] v, input bit drop_en, output int rise);
        int e;
        ch_sample = s;
        ch_valid  = v;
        mix_ready = 1'b1;
        e = model(s, v);
        wait_rise(rise);
        if (drop_en) enable = 1'b0;
        @(negedge clk); check("step_hi2", step, 1);
        @(negedge clk); check("step_lo", step, 0);
        repeat (4) @(negedge clk);
        check("valid_early", mix_valid, 0);
        @(negedge clk);
        check("valid", mix_valid, 1);
        check("mix_out", mix_out, e);
        @(negedge clk); check("valid_drop", mix_valid, 0);
    endtask

    initial begin
        int r, r2, rel, prev, e, nstep;
        logic [63:0] s;
        #3;
        check("rst_step", step, 0);
        check("rst_valid", mix_valid, 0);
        check("rst_mix", mix_out, 0);
        check("rst_ovr", overrun, 0);
        repeat (3) @(negedge clk);
        check("rst_hold_step", step, 0);
        reset = 1'b1;
        rel = cyc;
        txn({16'sd0, -16'sd500, 16'sd2000, 16'sd1000}, 4'hF, 1'b0, r);
        check("first_tick_delay", r - rel, 16);
        txn({4{16'sh7fff}}, 4'hF, 1'b0, r);
        txn({4{16'sh8000}}, 4'hF, 1'b0, r);
        txn({4{16'sd100}}, 4'b0101, 1'b0, r);
        prev = r;
        for (int k = 0; k < 10; k++) begin
            txn({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'b0, r);
            check("step_spacing", r - prev, 16);
            prev = r;
        end
        check("no_overrun", overrun, 0);
        // Hold the output past the next tick; a clear coinciding with that tick must lose.
        s = {$urandom, $urandom};
        ch_sample = s;
        ch_valid  = 4'hF;
        e = model(s, 4'hF);
        mix_ready = 1'b0;
        wait_rise(r);
        repeat (7) @(negedge clk);
        check("hold_valid", mix_valid, 1);
        check("hold_mix", mix_out, e);
        check("ovr_before", overrun, 0);
        for (int c = 9; c <= 27; c++) begin
            @(negedge clk);
            if (c == 16) overrun_clr = 1'b1;
            if (c == 17) begin
                overrun_clr = 1'b0;
                check("ovr_set_wins", overrun, 1);
            end
            check("hold_valid_c", mix_valid, 1);
            check("hold_stable", mix_out, e);
        end
        mix_ready = 1'b1;
        @(negedge clk);
        check("release_valid", mix_valid, 0);
        check("ovr_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        txn({$urandom, $urandom}, 4'hF, 1'b0, r2);
        check("tick_dropped", r2 - r, 32);
        // Enable dropped mid-transaction: it completes, then no new steps appear.
        txn({4{16'sd1234}}, 4'b0011, 1'b1, r);
        nstep = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (step) nstep++;
        end
        check("no_step_disabled", nstep, 0);
        enable = 1'b1;
        txn({16'sd7, -16'sd3000, 16'sd300, -16'sd20}, 4'b1110, 1'b0, r);
        txn({4{16'sh8000}}, 4'hF, 1'b0, r);
        ch_sample = {4{16'sd555}};
        wait_rise(r);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_step", step, 0);
        check("midrst_valid", mix_valid, 0);
        check("midrst_mix", mix_out, 0);
        @(negedge clk);
        reset = 1'b1;
        rel = cyc;
        txn({16'sd4000, 16'sd3000, -16'sd1000, 16'sd250}, 4'hF, 1'b0, r);
        check("rst_tick_delay", r - rel, 16);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
